alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Instruction-side initiator for the combinational 32-bit ALU. It accepts RV32I integer register and immediate ALU instructions, with operand values already read, over a valid/ready handshake. It decodes each instruction into the ALU's 4-bit opcode and operand pair, holds them stable for one execute cycle, and captures the ALU result and flags into a registered response port with backpressure. It sits between the register-read stage and writeback, and it is the only driver of the ALU's inputs.

## Interface
- DATA_WIDTH, 32, operand/result width; only 32 is supported
- CONTROL, 4, ALU opcode width
- CNT_WIDTH, 16, width of the retired-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready at a rising edge
- in_instr  in  32  RV32I instruction word
- in_rs1_data  in  32  rs1 value
- in_rs2_data  in  32  rs2 value; ignored for OP-IMM
- alu_a  out  32  ALU operand A, registered
- alu_b  out  32  ALU operand B, registered
- alu_opcode  out  4  ALU opcode, registered
- alu_result  in  32  ALU combinational result
- alu_flags  in  5  {auxillary, carry, sign, zero, parity} from the ALU
- out_valid  out  1  response available
- out_ready  in  1  response consumed when out_valid && out_ready at a rising edge
- out_rd  out  5  destination register, instr[11:7]
- out_data  out  32  captured result
- out_flags  out  5  captured flags
- out_illegal  out  1  instruction not executable on the ALU
- retire_cnt  out  CNT_WIDTH  number of responses consumed; wraps to 0

## Operation
- ALU opcode encoding:
  - opcode[1:0]=00 is add/sub; opcode[2] set selects subtract.
  - opcode[1:0]=10 is bitwise; opcode[3:2] selects 00 AND, 01 OR, 10 NOT, 11 XOR.
  - opcode[1:0]=11 is shift; opcode[3:2] selects 00 >>, 01 <<, 10 <<<, 11 >>>.
- Decode for OP (instr[6:0]=0110011), keyed on funct7/funct3:
  - ADD 0000000/000 -> 0000
  - SUB 0100000/000 -> 0100
  - SLL 0000000/001 -> 0111
  - SRL 0000000/101 -> 0011
  - SRA 0100000/101 -> 1111
  - XOR 0000000/100 -> 1110
  - OR 0000000/110 -> 0110
  - AND 0000000/111 -> 0010
- Decode for OP-IMM (0010011): ADDI, XORI, ORI, ANDI, SLLI, SRLI and SRAI use the same mapping.
  - alu_b = sign-extended instr[31:20].
  - For shifts, alu_b = {27'b0, instr[24:20]}.
  - SLLI and SRLI require funct7=0000000; SRAI requires funct7=0100000.
- For register shifts, alu_b = {27'b0, rs2[4:0]}. The ALU shifts by the full operand, so masking happens here.
- alu_a = rs1 for every legal instruction.
- Illegal instructions: any other opcode, funct3 or funct7, including SLT, SLTU, SLTI and SLTIU.
  - Response: out_illegal=1, out_data=0, out_flags=0.
  - alu_a, alu_b and alu_opcode keep their previous values.
- FSM with three states: IDLE, EXEC, RESP.
  - IDLE, accept of a legal instruction: register operands and opcode; go to EXEC.
  - IDLE, accept of an illegal instruction: load the response directly; go to RESP.
  - EXEC: capture alu_result and alu_flags into out_data and out_flags; out_illegal=0; go to RESP. EXEC always lasts exactly one cycle.
  - RESP without out_ready: hold every output stable.
  - RESP with out_ready and no accept: go to IDLE.
  - RESP with out_ready and an accept: same as an IDLE accept (go to EXEC or reload RESP).
- in_ready = (state==IDLE) || (state==RESP && out_ready). It is combinational from state and out_ready.
- out_valid = (state==RESP).
- retire_cnt increments on every out handshake, legal or illegal. It wraps from 2^CNT_WIDTH-1 to 0.
- out_rd is reported as decoded, including rd=0. Suppressing writes to x0 is writeback's job.

## Timing
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - in_ready=1.
  - out_valid=0 and out_illegal=0.
  - alu_a, alu_b, alu_opcode, out_rd, out_data, out_flags and retire_cnt all 0.
- Reset during EXEC or RESP drops the in-flight instruction; no response is produced.
- Legal-instruction latency: accept at edge E0, out_valid high after E1. ALU inputs are stable for the whole E0–E1 cycle.
- Illegal-instruction latency: out_valid high after E0.
- Throughput with out_ready held at 1: one legal result every 2 cycles, one illegal result every cycle.
- While out_valid=1 and out_ready=0, out_rd, out_data, out_flags and out_illegal must not change.

## Test plan
- ADD x3,x1,x2: in_instr=0x002081B3, rs1=5, rs2=7.
  - Expect alu_opcode=0000 during EXEC.
  - Expect out_valid 2 edges after accept, out_rd=3, out_data=12, out_flags[1]=0 (zero).
- SUB x3,x1,x2: in_instr=0x402081B3, rs1=rs2=9.
  - Expect alu_opcode=0100, out_data=0, out_flags zero bit=1.
- ADDI x1,x0,-1: in_instr=0xFFF00093, rs1=10.
  - Expect alu_b=0xFFFFFFFF, out_data=9.
- SRAI x5,x6,4: in_instr=0x40435293, rs1=0x80000000.
  - Expect alu_opcode=1111, alu_b=4, out_data equal to alu_result sampled in EXEC.
- Register shift mask: SLL with rs2=0x00000021.
  - Expect alu_b=1, alu_opcode=0111.
- Illegal SLT: in_instr=0x0020A1B3.
  - Expect out_valid after 1 edge, out_illegal=1, out_data=0, alu_* unchanged.
- Backpressure: hold out_ready=0 for 3 cycles in RESP.
  - Expect in_ready=0 and outputs stable throughout.
  - On release with in_valid=1, expect the new instruction accepted on the same edge.
  - Expect retire_cnt +1.
- Reset mid-EXEC: pull rst_n low.
  - Expect out_valid=0 and retire_cnt=0 immediately.
  - Expect in_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational 32-bit ALU: decodes RV32I OP/OP-IMM
// instructions, drives registered ALU inputs for one cycle and returns the result.
module alu_issue_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CONTROL    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [DATA_WIDTH-1:0] in_rs2_data,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [CONTROL-1:0]    alu_opcode,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [4:0]            alu_flags,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_rd,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [4:0]            out_flags,
    output logic                  out_illegal,
    output logic [CNT_WIDTH-1:0]  retire_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [CONTROL-1:0] ALU_ADD = CONTROL'(4'b0000);
    localparam logic [CONTROL-1:0] ALU_SUB = CONTROL'(4'b0100);
    localparam logic [CONTROL-1:0] ALU_AND = CONTROL'(4'b0010);
    localparam logic [CONTROL-1:0] ALU_OR  = CONTROL'(4'b0110);
    localparam logic [CONTROL-1:0] ALU_XOR = CONTROL'(4'b1110);
    localparam logic [CONTROL-1:0] ALU_SRL = CONTROL'(4'b0011);
    localparam logic [CONTROL-1:0] ALU_SLL = CONTROL'(4'b0111);
    localparam logic [CONTROL-1:0] ALU_SRA = CONTROL'(4'b1111);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [CONTROL-1:0]    alu_opcode_q, alu_opcode_d;
    logic [4:0]            out_rd_q, out_rd_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [4:0]            out_flags_q, out_flags_d;
    logic                  out_illegal_q, out_illegal_d;
    logic [CNT_WIDTH-1:0]  retire_cnt_q, retire_cnt_d;

    logic [6:0]            instr_opc;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [DATA_WIDTH-1:0] imm_sext;
    logic [DATA_WIDTH-1:0] imm_shamt;
    logic [DATA_WIDTH-1:0] rs2_shamt;
    logic                  dec_legal;
    logic [CONTROL-1:0]    dec_opcode;
    logic [DATA_WIDTH-1:0] dec_b;
    logic                  accept;
    logic                  out_fire;
    logic                  unused_rs_fields;

    assign instr_opc = in_instr[6:0];
    assign funct3    = in_instr[14:12];
    assign funct7    = in_instr[31:25];
    assign imm_sext  = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_shamt = {{(DATA_WIDTH-5){1'b0}}, in_instr[24:20]};
    // The ALU shifts by the whole operand, so register shift amounts are masked here.
    assign rs2_shamt = {{(DATA_WIDTH-5){1'b0}}, in_rs2_data[4:0]};
    // Register specifiers arrive as already-read data; only rd is used from the word.
    assign unused_rs_fields = ^in_instr[19:15];

    always_comb begin
        dec_legal  = 1'b0;
        dec_opcode = ALU_ADD;
        dec_b      = in_rs2_data;
        case (instr_opc)
            OPC_OP: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE) begin
                            dec_legal  = 1'b1;
                            dec_opcode = ALU_ADD;
                        end else if (funct7 == F7_ALT) begin
                            dec_legal  = 1'b1;
                            dec_opcode = ALU_SUB;
                        end
                    end
                    3'b001: begin
                        dec_b = rs2_shamt;
                        if (funct7 == F7_BASE) begin
                            dec_legal  = 1'b1;
                            dec_opcode = ALU_SLL;
                        end
                    end
                    3'b100: begin
                        dec_legal  = (funct7 == F7_BASE);
                        dec_opcode = ALU_XOR;
                    end
                    3'b101: begin
                        dec_b = rs2_shamt;
                        if (funct7 == F7_BASE) begin
                            dec_legal  = 1'b1;
                            dec_opcode = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_legal  = 1'b1;
                            dec_opcode = ALU_SRA;
                        end
                    end
                    3'b110: begin
                        dec_legal  = (funct7 == F7_BASE);
                        dec_opcode = ALU_OR;
                    end
                    3'b111: begin
                        dec_legal  = (funct7 == F7_BASE);
                        dec_opcode = ALU_AND;
                    end
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                dec_b = imm_sext;
                case (funct3)
                    3'b000: begin
                        dec_legal  = 1'b1;
                        dec_opcode = ALU_ADD;
                    end
                    3'b001: begin
                        dec_b = imm_shamt;
                        if (funct7 == F7_BASE) begin
                            dec_legal  = 1'b1;
                            dec_opcode = ALU_SLL;
                        end
                    end
                    3'b100: begin
                        dec_legal  = 1'b1;
                        dec_opcode = ALU_XOR;
                    end
                    3'b101: begin
                        dec_b = imm_shamt;
                        if (funct7 == F7_BASE) begin
                            dec_legal  = 1'b1;
                            dec_opcode = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_legal  = 1'b1;
                            dec_opcode = ALU_SRA;
                        end
                    end
                    3'b110: begin
                        dec_legal  = 1'b1;
                        dec_opcode = ALU_OR;
                    end
                    3'b111: begin
                        dec_legal  = 1'b1;
                        dec_opcode = ALU_AND;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign in_ready = (state_q == IDLE) || ((state_q == RESP) && out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = (state_q == RESP) && out_ready;

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_opcode_d  = alu_opcode_q;
        out_rd_d      = out_rd_q;
        out_data_d    = out_data_q;
        out_flags_d   = out_flags_q;
        out_illegal_d = out_illegal_q;
        retire_cnt_d  = retire_cnt_q;

        case (state_q)
            IDLE: ;
            EXEC: begin
                state_d       = RESP;
                out_data_d    = alu_result;
                out_flags_d   = alu_flags;
                out_illegal_d = 1'b0;
            end
            RESP: begin
                if (out_ready) begin
                    state_d      = IDLE;
                    retire_cnt_d = retire_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = IDLE;
        endcase

        // An accept in RESP coincides with the response handshake, so it overrides the IDLE return.
        if (accept) begin
            out_rd_d = in_instr[11:7];
            if (dec_legal) begin
                state_d      = EXEC;
                alu_a_d      = in_rs1_data;
                alu_b_d      = dec_b;
                alu_opcode_d = dec_opcode;
            end else begin
                state_d       = RESP;
                out_data_d    = '0;
                out_flags_d   = '0;
                out_illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_opcode_q  <= '0;
            out_rd_q      <= '0;
            out_data_q    <= '0;
            out_flags_q   <= '0;
            out_illegal_q <= 1'b0;
            retire_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_opcode_q  <= alu_opcode_d;
            out_rd_q      <= out_rd_d;
            out_data_q    <= out_data_d;
            out_flags_q   <= out_flags_d;
            out_illegal_q <= out_illegal_d;
            retire_cnt_q  <= retire_cnt_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opcode  = alu_opcode_q;
    assign out_valid   = (state_q == RESP);
    assign out_rd      = out_rd_q;
    assign out_data    = out_data_q;
    assign out_flags   = out_flags_q;
    assign out_illegal = out_illegal_q;
    assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed cases, then random traffic scored against
// an instruction-level RV32I reference model with a stand-in ALU.
module tb_alu_issue_ctrl;

    localparam int CW = 6;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_rs1_data;
    logic [31:0]   in_rs2_data;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [3:0]    alu_opcode;
    logic [31:0]   alu_result;
    logic [4:0]    alu_flags;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    out_rd;
    logic [31:0]   out_data;
    logic [4:0]    out_flags;
    logic          out_illegal;
    logic [CW-1:0] retire_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic mon_en = 1'b0;
    int exp_ret = 0;

    typedef struct {
        int          due;
        logic        ill;
        logic [31:0] data;
        logic [4:0]  flags;
        logic [4:0]  rd;
    } exp_t;
    exp_t q[$];

    alu_issue_ctrl #(
        .DATA_WIDTH(32),
        .CONTROL(4),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .in_rs1_data(in_rs1_data),
        .in_rs2_data(in_rs2_data),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .alu_flags(alu_flags),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_rd(out_rd),
        .out_data(out_data),
        .out_flags(out_flags),
        .out_illegal(out_illegal),
        .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stand-in ALU flags: {aux, carry, sign, zero, parity}, any deterministic function works.
    function automatic logic [4:0] flag_fn(input logic [31:0] r);
        return {r[4] ^ r[0], r[31] ^ r[30], r[31], r == 32'd0, ^r};
    endfunction

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        logic [31:0] r;
        r = 32'd0;
        case (op[1:0])
            2'b00: r = op[2] ? a - b : a + b;
            2'b10: begin
                case (op[3:2])
                    2'b00: r = a & b;
                    2'b01: r = a | b;
                    2'b10: r = ~a;
                    default: r = a ^ b;
                endcase
            end
            2'b11: begin
                case (op[3:2])
                    2'b00: r = a >> b;
                    2'b01: r = a << b;
                    2'b10: r = a <<< b;
                    default: r = $signed(a) >>> b;
                endcase
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_a, alu_b, alu_opcode);
        alu_flags  = flag_fn(alu_result);
    end

    // Architectural RV32I semantics for the supported subset.
    task automatic ref_exec(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                            output logic legal, output logic [31:0] res);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [4:0]  sh;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        imm = {{20{ins[31]}}, ins[31:20]};
        sh  = ins[24:20];
        legal = 1'b1;
        res   = 32'd0;
        if (op == 7'h33) begin
            case ({f7, f3})
                {7'h00, 3'd0}: res = r1 + r2;
                {7'h20, 3'd0}: res = r1 - r2;
                {7'h00, 3'd1}: res = r1 << r2[4:0];
                {7'h00, 3'd5}: res = r1 >> r2[4:0];
                {7'h20, 3'd5}: res = $signed(r1) >>> r2[4:0];
                {7'h00, 3'd4}: res = r1 ^ r2;
                {7'h00, 3'd6}: res = r1 | r2;
                {7'h00, 3'd7}: res = r1 & r2;
                default: legal = 1'b0;
            endcase
        end else if (op == 7'h13) begin
            case (f3)
                3'd0: res = r1 + imm;
                3'd4: res = r1 ^ imm;
                3'd6: res = r1 | imm;
                3'd7: res = r1 & imm;
                3'd1: if (f7 == 7'h00) res = r1 << sh; else legal = 1'b0;
                3'd5: begin
                    if (f7 == 7'h00) res = r1 >> sh;
                    else if (f7 == 7'h20) res = $signed(r1) >>> sh;
                    else legal = 1'b0;
                end
                default: legal = 1'b0;
            endcase
        end else begin
            legal = 1'b0;
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int k;
        int w;
        k  = int'($urandom_range(0, 9));
        w  = int'($urandom_range(0, 9));
        f3 = 3'($urandom_range(0, 7));
        if (w < 6) f7 = 7'h00;
        else if (w < 9) f7 = 7'h20;
        else f7 = 7'($urandom);
        if (k < 4) begin
            op = 7'h33;
        end else if (k < 8) begin
            op = 7'h13;
            if (f3 != 3'd1 && f3 != 3'd5) f7 = 7'($urandom);
        end else if (k == 8) begin
            op = ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h13;
            f3 = 3'($urandom_range(2, 3));
            f7 = 7'h00;
        end else begin
            op = 7'($urandom);
        end
        return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), op};
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            logic        exp_valid;
            logic        exp_rdy;
            logic        legal;
            logic [31:0] res;
            exp_t        e;
            exp_valid = (q.size() > 0) && (cyc >= q[0].due);
            exp_rdy   = (q.size() == 0) || (exp_valid && out_ready);
            check("rnd_out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            check("rnd_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            check("rnd_retire_cnt", {26'd0, retire_cnt}, 32'(exp_ret));
            if (exp_valid) begin
                check("rnd_out_data", out_data, q[0].data);
                check("rnd_out_flags", {27'd0, out_flags}, {27'd0, q[0].flags});
                check("rnd_out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
                check("rnd_out_illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
                if (out_ready) begin
                    void'(q.pop_front());
                    exp_ret = (exp_ret + 1) % (1 << CW);
                end
            end
            if (in_valid && exp_rdy) begin
                ref_exec(in_instr, in_rs1_data, in_rs2_data, legal, res);
                e.due   = cyc + (legal ? 2 : 1);
                e.ill   = !legal;
                e.data  = legal ? res : 32'd0;
                e.flags = legal ? flag_fn(res) : 5'd0;
                e.rd    = in_instr[11:7];
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        in_instr    = ins;
        in_rs1_data = r1;
        in_rs2_data = r2;
        in_valid    = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] saved;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_instr    = 32'd0;
        in_rs1_data = 32'd0;
        in_rs2_data = 32'd0;

        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_flags", {27'd0, out_flags}, 32'd0);
        check("rst_retire", {26'd0, retire_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ADD x3,x1,x2
        issue(32'h0020_81B3, 32'd5, 32'd7);
        check("add_opcode", {28'd0, alu_opcode}, 32'h0);
        check("add_alu_a", alu_a, 32'd5);
        check("add_exec_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_rd", {27'd0, out_rd}, 32'd3);
        check("add_data", out_data, 32'd12);
        check("add_zero", {31'd0, out_flags[1]}, 32'd0);
        consume();
        check("add_retire", {26'd0, retire_cnt}, 32'd1);
        check("add_idle_valid", {31'd0, out_valid}, 32'd0);

        // SUB with equal operands
        issue(32'h4020_81B3, 32'd9, 32'd9);
        check("sub_opcode", {28'd0, alu_opcode}, 32'h4);
        step();
        check("sub_data", out_data, 32'd0);
        check("sub_zero", {31'd0, out_flags[1]}, 32'd1);
        consume();

        // ADDI x1,x0,-1
        issue(32'hFFF0_0093, 32'd10, 32'h1234_5678);
        check("addi_alu_b", alu_b, 32'hFFFF_FFFF);
        step();
        check("addi_data", out_data, 32'd9);
        check("addi_rd", {27'd0, out_rd}, 32'd1);
        consume();

        // SRAI x5,x6,4
        issue(32'h4043_5293, 32'h8000_0000, 32'd0);
        check("srai_opcode", {28'd0, alu_opcode}, 32'hF);
        check("srai_alu_b", alu_b, 32'd4);
        saved = alu_result;
        step();
        check("srai_data_vs_exec", out_data, saved);
        check("srai_data", out_data, 32'hF800_0000);
        check("srai_rd", {27'd0, out_rd}, 32'd5);
        consume();

        // SLL x3,x1,x2 with an out-of-range shift amount
        issue(32'h0020_91B3, 32'd3, 32'h0000_0021);
        check("sll_alu_b", alu_b, 32'd1);
        check("sll_opcode", {28'd0, alu_opcode}, 32'h7);
        step();
        check("sll_data", out_data, 32'd6);
        consume();
        check("sll_retire", {26'd0, retire_cnt}, 32'd5);

        // Illegal SLT: one-cycle response, ALU inputs untouched
        issue(32'h0020_A1B3, 32'd1, 32'd2);
        check("slt_valid", {31'd0, out_valid}, 32'd1);
        check("slt_illegal", {31'd0, out_illegal}, 32'd1);
        check("slt_data", out_data, 32'd0);
        check("slt_flags", {27'd0, out_flags}, 32'd0);
        check("slt_rd", {27'd0, out_rd}, 32'd3);
        check("slt_alu_a", alu_a, 32'd3);
        check("slt_alu_b", alu_b, 32'd1);
        check("slt_opcode", {28'd0, alu_opcode}, 32'h7);

        // Backpressure for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_illegal", {31'd0, out_illegal}, 32'd1);
            check("bp_data", out_data, 32'd0);
            check("bp_rd", {27'd0, out_rd}, 32'd3);
            check("bp_retire", {26'd0, retire_cnt}, 32'd5);
        end
        in_instr    = 32'h0020_8233;
        in_rs1_data = 32'd20;
        in_rs2_data = 32'd22;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rel_retire", {26'd0, retire_cnt}, 32'd6);
        check("rel_exec_valid", {31'd0, out_valid}, 32'd0);
        check("rel_alu_a", alu_a, 32'd20);
        step();
        check("rel_valid", {31'd0, out_valid}, 32'd1);
        check("rel_data", out_data, 32'd42);
        check("rel_rd", {27'd0, out_rd}, 32'd4);
        check("rel_illegal", {31'd0, out_illegal}, 32'd0);
        consume();

        // Reset while in EXEC
        issue(32'h0020_81B3, 32'd1, 32'd1);
        check("mr_exec_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mr_valid", {31'd0, out_valid}, 32'd0);
        check("mr_retire", {26'd0, retire_cnt}, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        check("mr_alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("mr_post_in_ready", {31'd0, in_ready}, 32'd1);
        check("mr_post_valid", {31'd0, out_valid}, 32'd0);

        // Random traffic against the reference model
        exp_ret = 0;
        mon_en  = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_instr    = gen_instr();
            in_rs1_data = rand_data();
            in_rs2_data = rand_data();
            out_ready   = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        mon_en = 1'b0;
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
